// File: rtl/adder_alu.sv
// Parametrised arithmetic unit: ADD, SUB, running accumulator and shift-add MUL,
// launched on the rising edge of a synchronized start level.
module adder_alu #(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [1:0]         op,
   input  logic               start,
   input  logic               clr,
   output logic [2*WIDTH-1:0] result,
   output logic               carry,
   output logic               zero,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic                 start_q, start_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 carry_q, carry_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic                 launch;
   logic [WIDTH:0]       add_sum;
   logic [WIDTH-1:0]     sub_diff;
   logic [WIDTH:0]       acc_sum;
   logic [WIDTH-1:0]     acc_new;
   logic [2*WIDTH-1:0]   prod_step;

   always_comb begin
      state_d   = state_q;
      start_d   = start;
      result_d  = result_q;
      carry_d   = carry_q;
      done_d    = 1'b0;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;

      // An edge seen while a MUL is running is consumed by start_q and lost.
      launch    = start & ~start_q & (state_q == IDLE);
      add_sum   = {1'b0, a} + {1'b0, b};
      sub_diff  = a - b;
      acc_sum   = {1'b0, acc_q} + {1'b0, a};
      acc_new   = (SATURATE && acc_sum[WIDTH]) ? '1 : acc_sum[WIDTH-1:0];
      prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

      if (clr) begin
         state_d  = IDLE;
         result_d = '0;
         carry_d  = 1'b0;
         acc_d    = '0;
         prod_d   = '0;
         cnt_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (launch) begin
                  case (op)
                     OP_ADD: begin
                        result_d = {{(WIDTH-1){1'b0}}, add_sum};
                        carry_d  = add_sum[WIDTH];
                        done_d   = 1'b1;
                     end
                     OP_SUB: begin
                        result_d = {{WIDTH{1'b0}}, sub_diff};
                        carry_d  = (a < b);
                        done_d   = 1'b1;
                     end
                     OP_ACC: begin
                        acc_d    = acc_new;
                        result_d = {{WIDTH{1'b0}}, acc_new};
                        carry_d  = acc_sum[WIDTH];
                        done_d   = 1'b1;
                     end
                     OP_MUL: begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        prod_d   = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                     end
                     default: ;
                  endcase
               end
            end
            RUN: begin
               prod_d   = prod_step;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  result_d = prod_step;
                  carry_d  = 1'b0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         start_q  <= 1'b1;
         result_q <= '0;
         carry_q  <= 1'b0;
         done_q   <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         done_q   <= done_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
      end
   end

   assign result = result_q;
   assign carry  = carry_q;
   assign zero   = (result_q == '0);
   assign busy   = (state_q == RUN);
   assign done   = done_q;

endmodule

// File: tb/tb_adder_alu.sv
// Bench for adder_alu: wrapping and saturating instances share stimulus and are
// checked every cycle against an arithmetic model, plus literal expectations.
module tb_adder_alu;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic [1:0]     op = 2'b00;
   logic           start = 1'b1;
   logic           clr = 1'b0;

   logic [2*W-1:0] r0, r1;
   logic           c0, c1, z0, z1, bz0, bz1, d0, d1;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int busy_cnt = 0;

   adder_alu #(.WIDTH(W), .SATURATE(1'b0)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start), .clr(clr),
      .result(r0), .carry(c0), .zero(z0), .busy(bz0), .done(d0)
   );

   adder_alu #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start), .clr(clr),
      .result(r1), .carry(c1), .zero(z1), .busy(bz1), .done(d1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic model: index 0 wraps the accumulator, index 1 saturates it.
   int m_res[2];
   int m_carry[2];
   int m_acc[2];
   int m_done[2];
   int m_left = 0;
   int m_prod = 0;
   int m_prev = 1;
   int allones = (1 << W) - 1;

   initial begin
      for (int s = 0; s < 2; s++) begin
         m_res[s] = 0; m_carry[s] = 0; m_acc[s] = 0; m_done[s] = 0;
      end
   end

   always @(posedge clk) begin
      int s_sum;
      bit launch;
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            m_res[s] = 0; m_carry[s] = 0; m_acc[s] = 0; m_done[s] = 0;
         end
         m_left = 0;
         m_prev = 1;
      end else begin
         launch = start && (m_prev == 0) && (m_left == 0);
         for (int s = 0; s < 2; s++) m_done[s] = 0;
         if (clr) begin
            for (int s = 0; s < 2; s++) begin
               m_res[s] = 0; m_carry[s] = 0; m_acc[s] = 0;
            end
            m_left = 0;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               for (int s = 0; s < 2; s++) begin
                  m_res[s] = m_prod; m_carry[s] = 0; m_done[s] = 1;
               end
            end
         end else if (launch) begin
            for (int s = 0; s < 2; s++) begin
               case (op)
                  2'b00: begin
                     m_res[s] = int'(a) + int'(b);
                     m_carry[s] = (m_res[s] > allones) ? 1 : 0;
                     m_done[s] = 1;
                  end
                  2'b01: begin
                     m_res[s] = (int'(a) - int'(b) + allones + 1) % (allones + 1);
                     m_carry[s] = (a < b) ? 1 : 0;
                     m_done[s] = 1;
                  end
                  2'b10: begin
                     s_sum = m_acc[s] + int'(a);
                     m_carry[s] = (s_sum > allones) ? 1 : 0;
                     if (s_sum > allones) m_acc[s] = (s == 1) ? allones : s_sum - allones - 1;
                     else m_acc[s] = s_sum;
                     m_res[s] = m_acc[s];
                     m_done[s] = 1;
                  end
                  default: begin
                     m_left = W;
                     m_prod = int'(a) * int'(b);
                  end
               endcase
            end
         end
         m_prev = int'(start);
      end
   end

   // Per-cycle compare, just after the model and the DUT have both updated.
   always begin
      @(posedge clk);
      #1;
      chk("res_wrap",   32'(r0),  32'(m_res[0]));
      chk("carry_wrap", 32'(c0),  32'(m_carry[0]));
      chk("zero_wrap",  32'(z0),  32'(m_res[0] == 0));
      chk("busy_wrap",  32'(bz0), 32'(m_left > 0));
      chk("done_wrap",  32'(d0),  32'(m_done[0]));
      chk("res_sat",    32'(r1),  32'(m_res[1]));
      chk("carry_sat",  32'(c1),  32'(m_carry[1]));
      chk("zero_sat",   32'(z1),  32'(m_res[1] == 0));
      chk("busy_sat",   32'(bz1), 32'(m_left > 0));
      chk("done_sat",   32'(d1),  32'(m_done[1]));
      if (d0) done_cnt++;
      if (bz0) busy_cnt++;
   end

   task automatic pulse(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
      @(negedge clk);
      op = o; a = va; b = vb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (d0) seen = 1'b1;
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   int d_base, b_base;

   initial begin
      // Reset with start held high, then release reset with start still high.
      repeat (3) @(negedge clk);
      chk("rst_result", 32'(r0), 32'h0);
      chk("rst_zero",   32'(z0), 32'h1);
      chk("rst_busy",   32'(bz0), 32'h0);
      chk("rst_done",   32'(d0), 32'h0);
      chk("rst_carry",  32'(c0), 32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("held_start_no_op", 32'(done_cnt), 32'd0);
      start = 1'b0;
      @(negedge clk);

      pulse(2'b00, 8'd200, 8'd100);
      chk("add_result", 32'(r0), 32'h012C);
      chk("add_carry",  32'(c0), 32'h1);
      chk("add_zero",   32'(z0), 32'h0);
      chk("add_done",   32'(d0), 32'h1);
      @(negedge clk);
      chk("add_done_width", 32'(d0), 32'h0);

      pulse(2'b01, 8'd5, 8'd7);
      chk("sub_result", 32'(r0), 32'h00FE);
      chk("sub_borrow", 32'(c0), 32'h1);
      pulse(2'b01, 8'd7, 8'd7);
      chk("sub_eq_result", 32'(r0), 32'h0);
      chk("sub_eq_carry",  32'(c0), 32'h0);
      chk("sub_eq_zero",   32'(z0), 32'h1);

      pulse(2'b10, 8'd100, 8'd55);
      chk("acc1_wrap", 32'(r0), 32'd100);
      chk("acc1_sat",  32'(r1), 32'd100);
      pulse(2'b10, 8'd100, 8'd3);
      chk("acc2_wrap", 32'(r0), 32'd200);
      chk("acc2_sat",  32'(r1), 32'd200);
      pulse(2'b10, 8'd100, 8'd9);
      chk("acc3_wrap", 32'(r0), 32'd44);
      chk("acc3_wrap_carry", 32'(c0), 32'h1);
      chk("acc3_sat",  32'(r1), 32'd255);
      chk("acc3_sat_carry", 32'(c1), 32'h1);

      // MUL 255*255 with a second start edge while busy.
      d_base = done_cnt;
      b_base = busy_cnt;
      pulse(2'b11, 8'd255, 8'd255);
      chk("mul_busy_start", 32'(bz0), 32'h1);
      pulse(2'b00, 8'd1, 8'd1);
      wait_done("mul_done_seen");
      chk("mul_result", 32'(r0), 32'hFE01);
      chk("mul_carry",  32'(c0), 32'h0);
      chk("mul_busy_end", 32'(bz0), 32'h0);
      repeat (5) @(negedge clk);
      chk("mul_busy_cycles", 32'(busy_cnt - b_base), 32'd8);
      chk("mul_one_done",    32'(done_cnt - d_base), 32'd1);
      chk("mul_result_hold", 32'(r0), 32'hFE01);

      // Start held high for 20 cycles produces one ADD.
      d_base = done_cnt;
      @(negedge clk);
      op = 2'b00; a = 8'd1; b = 8'd2; start = 1'b1;
      repeat (20) @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("held_one_done", 32'(done_cnt - d_base), 32'd1);
      chk("held_result",   32'(r0), 32'd3);

      // A complete MUL 13*11, then aborted with clr and with rst.
      pulse(2'b11, 8'd13, 8'd11);
      wait_done("mul2_done_seen");
      chk("mul2_result", 32'(r0), 32'd143);

      d_base = done_cnt;
      pulse(2'b11, 8'd13, 8'd11);
      repeat (3) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_busy",   32'(bz0), 32'h0);
      chk("clr_result", 32'(r0), 32'h0);
      chk("clr_zero",   32'(z0), 32'h1);
      repeat (10) @(negedge clk);
      chk("clr_no_done", 32'(done_cnt - d_base), 32'd0);

      pulse(2'b00, 8'd255, 8'd255);
      chk("add_max_result", 32'(r0), 32'h01FE);
      d_base = done_cnt;
      pulse(2'b11, 8'd13, 8'd11);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_busy",   32'(bz0), 32'h0);
      chk("rst2_result", 32'(r0), 32'h0);
      chk("rst2_zero",   32'(z0), 32'h1);
      chk("rst2_carry",  32'(c0), 32'h0);
      repeat (10) @(negedge clk);
      chk("rst2_no_done", 32'(done_cnt - d_base), 32'd0);

      // Accumulator must be cleared by reset.
      pulse(2'b10, 8'd7, 8'd0);
      chk("acc_after_rst", 32'(r0), 32'd7);
      pulse(2'b01, 8'd0, 8'd1);
      chk("sub_wrap_result", 32'(r0), 32'h00FF);
      chk("sub_wrap_borrow", 32'(c0), 32'h1);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/adder_alu.md
# adder_alu

Parametrised arithmetic unit, successor to the board-level 8-bit switch adder. Takes two WIDTH-bit operands and a 2-bit opcode. On each rising edge of a start strobe it performs ADD, SUB, ACC (running accumulator) or MUL (multi-cycle shift-add), then registers the result and flags. It sits between the synchronized button/switch inputs and the LED/7-segment outputs of the board top level.

## Interface
- WIDTH, 8: operand width in bits (≥2).
- SATURATE, 0: 1 = ACC clamps at all-ones instead of wrapping.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand A (unsigned).
- b  in  WIDTH  operand B (unsigned).
- op  in  2  00 ADD, 01 SUB, 10 ACC, 11 MUL.
- start  in  1  level, active-high (already synchronized); an operation launches on its 0→1 edge.
- clr  in  1  synchronous clear of result, flags, accumulator; aborts MUL.
- result  out  2*WIDTH  registered result.
- carry  out  1  carry (ADD/ACC), borrow (SUB), 0 for MUL.
- zero  out  1  result == 0.
- busy  out  1  high while MUL in progress.
- done  out  1  one-cycle pulse when result/flags update from an operation.

## Operation
- Edge detect: start_q <= start each cycle; launch = start & ~start_q & ~busy. start_q resets to 1, so start held high through reset does not launch.
- Operands and op are sampled in the launch cycle only; later changes do not affect the operation in flight.
- ADD: result = {0, a+b}; the full WIDTH+1-bit sum sits in the low bits. carry = sum bit WIDTH.
- SUB: result low WIDTH = (a−b) mod 2^WIDTH, upper bits 0. carry = (a < b).
- ACC: acc (WIDTH bits) <= acc + a. carry = overflow of that add. With SATURATE=1, acc <= all-ones on overflow (carry still 1). result = zero-extended new acc. b is ignored.
- MUL: unsigned shift-add, one multiplier bit per cycle, WIDTH iterations. result = a*b (2*WIDTH bits), carry = 0.
- FSM states:
  - IDLE: launch with op=MUL → RUN, busy=1, counter=0, partial product cleared.
  - RUN: each cycle add the shifted multiplicand if the current multiplier bit is set; counter++. At counter==WIDTH−1, write result, pulse done, → IDLE.
  - Non-MUL launches complete in IDLE without a state change.
- Priority: rst > clr > launch. clr: result, acc, carry, zero→0 (zero=1 since result==0), busy=0, state→IDLE, no done pulse. clr and launch in the same cycle: clr wins and the launch is dropped.
- Edges during busy are ignored, not queued.
- result/carry/zero hold between operations. zero is derived from the registered result.

## Timing
- Reset values: result=0, carry=0, zero=1, busy=0, done=0, acc=0, state=IDLE, start_q=1.
- ADD/SUB/ACC: start rises before edge n (launch seen at edge n). result, flags and done are valid after edge n; latency 1 cycle.
- MUL: launch at edge n → busy=1 after edge n. result and done valid after edge n+WIDTH, busy=0 in the same cycle. Next launch is accepted at edge n+WIDTH+1.
- done is high for exactly 1 cycle per completed operation. It is never asserted on rst or clr.
- rst or clr mid-MUL: takes effect at that edge; partial product is discarded.

## Test plan
- ADD, WIDTH=8: a=200, b=100, start 0→1 → one cycle later result=0x012C, carry=1, zero=0, done pulse of width 1.
- SUB: a=5, b=7 → result=0x00FE, carry=1. Then a=7, b=7 → result=0, carry=0, zero=1.
- ACC: a=100, three separate start pulses. SATURATE=0 → results 100, 200, 44 with carry on the third. SATURATE=1 → 100, 200, 255.
- MUL: a=255, b=255 → busy high 8 cycles, result=0xFE01 and done one cycle after edge n+8. A start edge during busy → no second done, result unchanged.
- start held high 20 cycles with op=ADD → exactly one done pulse. start held high across rst deassertion → no operation.
- MUL a=13, b=11 with clr asserted at the 4th RUN cycle → next cycle busy=0, result=0, zero=1, no done. Repeat with rst → all outputs at reset values.
